// File: rtl/seq_count_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of the product port for a given operand width and result mode.
    function automatic int prod_width(input int width, input int full_product);
        return (full_product != 0) ? 2 * width : width;
    endfunction

endpackage

// File: rtl/seq_count_multiplier_if.sv
// Operand/result handshake bundle; master is the producer/consumer side.
interface seq_count_multiplier_if #(
    parameter int WIDTH = 4,
    parameter int PW    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    product;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, overflow, busy
    );
endinterface

// File: rtl/seq_count_multiplier_counter.sv
// Step counter for the RUN phase; last flags the final shift-add step.
module mult_step_counter #(
    parameter int WIDTH = 4
) (
    input  logic fast_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge fast_clk) begin
        if (rst || clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= cnt_q + CW'(1);
    end

    assign last = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/seq_count_multiplier.sv
// Sequential unsigned multiplier: one shift-add step per cycle for WIDTH cycles,
// result registered on entry to DONE and held until the consumer takes it.
module seq_count_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int FULL_PRODUCT = 0,
    parameter int SATURATE     = 0
) (
    input logic                   fast_clk,
    input logic                   rst,
    seq_count_multiplier_if.slave bus
);
    localparam int PW = prod_width(WIDTH, FULL_PRODUCT);
    localparam int W2 = 2 * WIDTH;

    mult_state_t     state_q;
    logic [W2-1:0]   acc_q;
    logic [W2-1:0]   a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [PW-1:0]   product_q;
    logic            overflow_q;

    logic            accept;
    logic            last;
    logic [W2-1:0]   acc_next;
    logic [PW-1:0]   result;
    logic            result_ov;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign acc_next = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    mult_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .fast_clk (fast_clk),
        .rst      (rst),
        .clear    (accept),
        .enable   (state_q == RUN),
        .last     (last)
    );

    // Result formatting works on acc_next so it can be latched on the final step.
    generate
        if (FULL_PRODUCT != 0) begin : g_full
            assign result    = acc_next;
            assign result_ov = 1'b0;
        end else begin : g_trunc
            logic ov;
            assign ov        = |acc_next[W2-1:WIDTH];
            assign result    = ((SATURATE != 0) && ov) ? '1 : acc_next[WIDTH-1:0];
            assign result_ov = ov;
        end
    endgenerate

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_sh_q  <= W2'(bus.a);
                    b_sh_q  <= bus.b;
                    acc_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q  <= acc_next;
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_q >> 1;
                    if (last) begin
                        product_q  <= result;
                        overflow_q <= result_ov;
                        state_q    <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.product   = product_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/seq_count_multiplier.md
Name: seq_count_multiplier

Overview:
- Parametrised sequential unsigned multiplier in the `fast_clk` domain.
- Successor to the fixed 4-bit counter-based multiply block: operand width is generic, full-width or truncated/saturated results are selectable, and operands and results use valid/ready handshakes.
- Uses a shift-add datapath sequenced by a step counter.
- Sits between an operand producer and a result consumer, one operation in flight at a time.

Parameters:
- WIDTH, 4: operand width in bits; legal for WIDTH ≥ 2.
- FULL_PRODUCT, 0: 1 gives `product` width 2*WIDTH; 0 gives `product` width WIDTH.
- SATURATE, 0: applies only when FULL_PRODUCT=0. 1 clamps the result to all-ones on overflow; 0 wraps (truncates).

Ports:
- fast_clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  `product` and `overflow` are valid.
- out_ready  in  1  consumer accepts the result.
- product  out  PW  result; PW = FULL_PRODUCT ? 2*WIDTH : WIDTH.
- overflow  out  1  true product does not fit in PW bits; always 0 when FULL_PRODUCT=1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (`rst`=1 at an edge):
  - state becomes IDLE; accumulator, shift registers and step counter clear to 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, product=0, overflow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: capture a into a_sh (2*WIDTH wide, zero-extended) and b into b_sh; clear acc and cnt; go to RUN.
- RUN (in_ready=0), each edge:
  - if b_sh[0], acc += a_sh (2*WIDTH-bit add, never overflows);
  - a_sh <<= 1; b_sh >>= 1; cnt++.
  - When cnt == WIDTH-1 at an edge, perform that final step and go to DONE.
  - RUN always lasts exactly WIDTH cycles. There is no early exit, including for operands equal to 0.
- DONE (in_ready=0, out_valid=1):
  - `product` and `overflow` are registered and held stable while out_valid=1 and out_ready=0.
  - When out_ready=1 at an edge: go to IDLE and drop out_valid.
- Latency: if operands are accepted at edge E, out_valid is high in the cycle after edge E+WIDTH.
- Throughput: minimum of WIDTH+2 cycles per operation (accept, WIDTH run cycles, DONE for at least one cycle).
- No bypass: in_ready stays 0 in DONE even while out_ready=1. New operands are accepted only from IDLE.
- Result formation (registered on entry to DONE):
  - FULL_PRODUCT=1: product = acc; overflow = 0.
  - FULL_PRODUCT=0: ov = |acc[2W-1:W].
    - SATURATE=0: product = acc[W-1:0].
    - SATURATE=1: product = ov ? all-ones : acc[W-1:0].
    - overflow = ov.
- in_valid while not in IDLE is ignored; the producer must hold in_valid and its data until in_ready.
- Reset in RUN or DONE aborts the operation immediately. The result is discarded and no out_valid pulse is generated.
- `rst` has priority over every handshake event at the same edge.
- Counter width is $clog2(WIDTH) bits. The count must never wrap inside RUN.

Decomposition:
- Package `seq_mult_pkg`:
  - state enum `mult_state_t` {IDLE, RUN, DONE};
  - localparam function for PW.
- Sub-module `mult_step_counter` (parameter WIDTH):
  - inputs: clear, enable;
  - output: `last`, asserted when cnt == WIDTH-1.
- FSM, datapath and result formatting stay in the top module.

Test Plan:
- WIDTH=4 defaults, a=3, b=5, out_ready=1:
  - product=15, overflow=0;
  - out_valid rises exactly 4 edges after the accept edge and lasts 1 cycle;
  - in_ready returns to 1 the following cycle.
- a=15, b=15:
  - SATURATE=0: product=1, overflow=1.
  - SATURATE=1: product=15, overflow=1.
  - FULL_PRODUCT=1: product=225, overflow=0.
- Exhaustive 16x16 sweep, driving new operands on the falling edge of `fast_clk` as soon as in_ready=1:
  - every result matches (a*b) mod 16, with overflow = (a*b > 15);
  - a=0 or b=0 gives product=0 with full latency.
- Backpressure, a=7, b=2: hold out_ready=0 for 3 cycles after out_valid.
  - product=14 stays stable;
  - in_ready=0 and in_valid is ignored throughout;
  - out_ready=1 then completes in one edge.
- Reset during RUN (2nd run cycle) with a=9, b=9:
  - next cycle shows in_ready=1, out_valid=0, product=0, overflow=0;
  - no out_valid ever appears for the aborted operation;
  - a following a=2, b=3 operation yields 6.
- WIDTH=8, FULL_PRODUCT=1, a=255, b=255: product=65025, latency 8 edges.
